// File: rtl/plab5_mcore_net_msg_to_mem_req_q.sv
// plab5_mcore_net_msg_to_mem_req_q: strips the network header, screens requester domain and queues memory requests for the bank
module plab5_mcore_net_msg_to_mem_req_q #(
    parameter int p_bank_domain       = 0,
    parameter int p_num_entries       = 2,
    parameter int p_mem_opaque_nbits  = 8,
    parameter int p_mem_addr_nbits    = 32,
    parameter int p_mem_data_nbits    = 32,
    parameter int p_net_opaque_nbits  = 4,
    parameter int p_net_srcdest_nbits = 3,
    localparam int L  = $clog2(p_mem_data_nbits / 8),
    localparam int C  = 3 + p_mem_opaque_nbits + p_mem_addr_nbits + L,
    localparam int NC = 2 * p_net_srcdest_nbits + p_net_opaque_nbits + C + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_val,
    output logic                          in_rdy,
    input  logic [NC-1:0]                 in_msg_control,
    input  logic [p_mem_data_nbits-1:0]   in_msg_data,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic [C+p_mem_data_nbits-1:0] out_msg,
    output logic [p_net_srcdest_nbits-1:0] out_src,
    output logic                          out_domain,
    output logic                          drop_err,
    output logic [7:0]                    drop_count
);
    localparam int NS = p_net_srcdest_nbits;
    localparam int AW = $clog2(p_num_entries);
    localparam int OW = $clog2(p_num_entries + 1);

    logic [C+p_mem_data_nbits-1:0] msg_q [p_num_entries];
    logic [NS-1:0]                 src_q [p_num_entries];
    logic                          dom_q [p_num_entries];
    logic [AW-1:0] head, tail;
    logic [OW-1:0] cnt;
    logic in_fire, drop, enq, deq;
    logic unused_net_hdr;

    // flag=1 means domain 0, which a secure bank refuses
    assign in_fire = in_val && in_rdy;
    assign drop    = in_fire && (p_bank_domain == 1) && in_msg_control[C];
    assign enq     = in_fire && !drop;
    assign deq     = out_val && out_rdy;

    assign in_rdy     = cnt < OW'(p_num_entries);
    assign out_val    = cnt != '0;
    assign out_msg    = msg_q[head];
    assign out_src    = src_q[head];
    assign out_domain = dom_q[head];

    assign unused_net_hdr = ^{in_msg_control[NC-1 -: NS], in_msg_control[NC-2*NS-1 -: p_net_opaque_nbits]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            cnt        <= '0;
            drop_err   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (enq) tail <= (tail == AW'(p_num_entries - 1)) ? '0 : tail + 1'b1;
            if (deq) head <= (head == AW'(p_num_entries - 1)) ? '0 : head + 1'b1;
            cnt        <= cnt + OW'(enq) - OW'(deq);
            drop_err   <= drop;
            if (drop && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            msg_q[tail] <= {in_msg_control[C-1:0], in_msg_data};
            src_q[tail] <= in_msg_control[NC-NS-1 -: NS];
            dom_q[tail] <= ~in_msg_control[C];
        end
    end
endmodule

// File: tb/tb_plab5_mcore_net_msg_to_mem_req_q.sv
// tb_plab5_mcore_net_msg_to_mem_req_q: scoreboard bench over an open bank (u[0]) and a secure bank (u[1])
module tb_plab5_mcore_net_msg_to_mem_req_q;
    localparam int NS = 3, NO = 4, MO = 8, MA = 32, MD = 32, L = 2, C = 45, NC = 56, N = 2;

    typedef struct packed {
        logic [C+MD-1:0] msg;
        logic [NS-1:0]   src;
        logic            dom;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic            in_val [2];
    logic            in_rdy [2];
    logic [NC-1:0]   ctrl [2];
    logic [MD-1:0]   data [2];
    logic            out_val [2];
    logic            out_rdy [2];
    logic [C+MD-1:0] out_msg [2];
    logic [NS-1:0]   out_src [2];
    logic            out_domain [2];
    logic            drop_err [2];
    logic [7:0]      drop_count [2];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        plab5_mcore_net_msg_to_mem_req_q #(.p_bank_domain(g), .p_num_entries(N)) dut (
            .clk(clk), .reset(reset),
            .in_val(in_val[g]), .in_rdy(in_rdy[g]),
            .in_msg_control(ctrl[g]), .in_msg_data(data[g]),
            .out_val(out_val[g]), .out_rdy(out_rdy[g]),
            .out_msg(out_msg[g]), .out_src(out_src[g]), .out_domain(out_domain[g]),
            .drop_err(drop_err[g]), .drop_count(drop_count[g])
        );
        ent_t q[$];
        ent_t e;
        logic exp_err = 1'b0;
        logic [7:0] exp_cnt = 8'd0;
        bit rdy;
        // models the upcoming posedge from the values settled at this negedge
        always @(negedge clk) begin
            if (!reset) begin
                q.delete();
                exp_err = 1'b0;
                exp_cnt = 8'd0;
            end
            rdy = q.size() < N;
            check($sformatf("in_rdy%0d", g), in_rdy[g], rdy);
            check($sformatf("out_val%0d", g), out_val[g], q.size() != 0);
            check($sformatf("drop_err%0d", g), drop_err[g], exp_err);
            check($sformatf("drop_count%0d", g), drop_count[g], exp_cnt);
            if (q.size() != 0) begin
                e = q[0];
                check($sformatf("out_msg%0d", g), out_msg[g], e.msg);
                check($sformatf("out_src%0d", g), out_src[g], e.src);
                check($sformatf("out_domain%0d", g), out_domain[g], e.dom);
                if (out_rdy[g]) void'(q.pop_front());
            end
            exp_err = 1'b0;
            if (reset && in_val[g] && rdy) begin
                if (g == 1 && ctrl[g][C]) begin
                    exp_err = 1'b1;
                    if (exp_cnt != 8'hff) exp_cnt++;
                end else
                    q.push_back('{msg: {ctrl[g][C-1:0], data[g]}, src: ctrl[g][NC-NS-1 -: NS], dom: ~ctrl[g][C]});
            end
        end
    end

    function automatic logic [NC-1:0] mk(input int src, input bit flag, input int typ,
                                         input int opq, input logic [MA-1:0] addr, input int len);
        return {NS'($urandom), NS'(src), NO'($urandom), flag, 3'(typ), MO'(opq), addr, L'(len)};
    endfunction

    task automatic send(input int g, input logic [NC-1:0] c, input logic [MD-1:0] d);
        bit fired;
        int t = 0;
        in_val[g] = 1'b1;
        ctrl[g] = c;
        data[g] = d;
        do begin
            @(negedge clk);
            fired = in_rdy[g];
            @(posedge clk);
            #1;
            t++;
        end while (!fired && t < 100);
        if (!fired) check("send_timeout", 0, 1);
        in_val[g] = 1'b0;
    endtask

    task automatic send_rand(input int g, input bit flag);
        int s = $urandom_range(0, 7);
        send(g, mk(s, flag, $urandom_range(0, 7), {s[2:0], 5'($urandom)}, $urandom, $urandom_range(0, 3)), $urandom);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_val[i] = 1'b0;
            out_rdy[i] = 1'b1;
            ctrl[i] = '0;
            data[i] = '0;
        end
        cycles(3);
        #1 reset = 1'b1;
        cycles(2);

        send(0, mk(1, 1'b0, 1, 8'h2A, 32'h0000C010, 0), 32'hDEADBEEF);
        @(negedge clk);
        check("t1_msg", out_msg[0], {3'd1, 8'h2A, 32'h0000C010, 2'd0, 32'hDEADBEEF});
        check("t1_src", out_src[0], 3'd1);
        check("t1_dom", out_domain[0], 1'b1);
        cycles(2);

        send(1, mk(0, 1'b1, 2, 8'h05, 32'h100, 1), 32'h12345678);
        @(negedge clk);
        check("t2_drop_err", drop_err[1], 1'b1);
        check("t2_drop_cnt", drop_count[1], 8'd1);
        check("t2_no_out", out_val[1], 1'b0);
        cycles(1);
        send(1, mk(1, 1'b0, 1, 8'h21, 32'h200, 2), 32'hCAFEF00D);
        cycles(3);

        out_rdy[0] = 1'b0;
        fork
            begin
                send_rand(0, 1'b0);
                send_rand(0, 1'b1);
                send_rand(0, 1'b0);
            end
            begin
                cycles(6);
                out_rdy[0] = 1'b1;
            end
        join
        cycles(4);

        fork
            for (int i = 0; i < 10; i++) send_rand(0, 1'($urandom));
            for (int i = 0; i < 10; i++) send_rand(1, 1'($urandom));
        join
        cycles(4);

        in_val[1] = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ctrl[1] = mk(0, 1'b1, 1, 0, $urandom, 0);
            data[1] = $urandom;
            cycles(1);
        end
        in_val[1] = 1'b0;
        @(negedge clk);
        check("t5_sat", drop_count[1], 8'd255);
        cycles(2);

        out_rdy[0] = 1'b0;
        out_rdy[1] = 1'b0;
        send_rand(0, 1'b0);
        send_rand(0, 1'b1);
        send_rand(1, 1'b0);
        send_rand(1, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("t6_val0", out_val[0], 1'b0);
        check("t6_rdy1", in_rdy[1], 1'b1);
        check("t6_cnt", drop_count[1], 8'd0);
        cycles(2);
        #1 reset = 1'b1;
        out_rdy[0] = 1'b1;
        out_rdy[1] = 1'b1;
        cycles(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/plab5_mcore_net_msg_to_mem_req_q.md
# plab5_mcore_net_msg_to_mem_req_q

Bank-side ingress stage of the memory request network. It accepts split control/data network messages produced by the core-side memory-request-to-network adapter, after the network has routed them. It strips the network header and recovers the requester's security domain from the payload flag bit. Each message is then either enqueued in a small FIFO that reconstructs a full memory request for the cache/memory bank, or dropped and counted when its domain is not permitted at this bank.

## Interface
- p_bank_domain, 0: bank security class; 1 = secure bank, which rejects domain-0 requesters; 0 = open bank, which accepts all.
- p_num_entries, 2: FIFO depth; must be ≥2.
- p_mem_opaque_nbits (mo), 8; p_mem_addr_nbits (ma), 32; p_mem_data_nbits (md), 32.
- p_net_opaque_nbits (no), 4; p_net_srcdest_nbits (ns), 3.
- Derived: L = clog2(md/8); C = 3+mo+ma+L (mem ctrl bits, 45 at defaults); NC = 2·ns+no+C+1 (net ctrl bits, 56 at defaults).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_val  in  1  network message valid.
- in_rdy  out  1  block can accept.
- in_msg_control  in  NC  layout MSB→LSB: {dest[ns], src[ns], net_opaque[no], flag[1], mem_ctrl[C]}.
- in_msg_data  in  md  write data; travels on the same handshake as the control word.
- out_val  out  1  memory request valid.
- out_rdy  in  1  bank accepts.
- out_msg  out  C+md  {mem_ctrl, data}, i.e. {type[3], opaque[mo], addr[ma], len[L], data[md]}.
- out_src  out  ns  network source of the request, used for response routing.
- out_domain  out  1  requester domain = ~flag.
- drop_err  out  1  one-cycle pulse on each dropped message.
- drop_count  out  8  saturating count of dropped messages.

## Operation
- Input fire: in_val && in_rdy. Output fire: out_val && out_rdy.
- in_rdy = (occupancy < p_num_entries). It depends only on fullness; dropped messages are still subject to in_rdy.
- Domain decode on input fire: dom = ~in_msg_control[C].
- Drop condition: p_bank_domain==1 && dom==0.
- On drop:
  - No enqueue.
  - drop_err = 1 in the next cycle.
  - drop_count increments and saturates at 255.
- Otherwise enqueue {mem_ctrl, data, src, dom}. dest and net_opaque are discarded.
- mem_ctrl is forwarded unchanged. The opaque top ns bits already hold the source and must not be modified.
- FIFO:
  - Circular buffer with head and tail pointers, each wrapping at p_num_entries−1 → 0, plus an occupancy counter of clog2(p_num_entries+1) bits.
  - out_val = (occupancy != 0). Outputs come from the head entry.
- Simultaneous enqueue and dequeue:
  - Occupancy unchanged; both pointers advance.
  - Legal at any occupancy where in_rdy=1. When full, in_rdy=0, so enqueue does not occur that cycle even if a dequeue does.
- Simultaneous drop and dequeue: occupancy decrements normally.
- Ordering: strict FIFO among accepted, non-dropped messages.
- Security labels:
  - control fields and in_rdy/out_val are Ctrl-domain.
  - in_msg_data/out_msg data bits are Data-domain.
  - drop_err/drop_count are L.

## Timing
- Reset asserted (asynchronous, any cycle): occupancy=0, head=tail=0, out_val=0, in_rdy=1, drop_err=0, drop_count=0.
- Pending entries are discarded. out_msg/out_src/out_domain are don't-care while out_val=0.
- Latency: a message enqueued at edge N is visible on out_* after edge N, valid in cycle N+1. There is no combinational in→out bypass.
- No combinational path from out_rdy to in_rdy.
- drop_err: asserted for exactly the cycle after the dropping edge. Back-to-back drops keep it high on consecutive cycles.
- Full: after p_num_entries enqueues with no dequeue, in_rdy=0 starting the next cycle. A dequeue at edge M raises in_rdy in cycle M+1.
- Empty dequeue (out_rdy=1, out_val=0): no effect.

## Test plan
- Reset, then p_bank_domain=0; send ctrl with src=1, flag=0, type=1, opaque=0x2A, addr=0x0000C010, len=0, data=0xDEADBEEF, holding out_rdy=1 → next cycle out_val=1, out_msg={1,0x2A,0x0000C010,0,0xDEADBEEF}, out_src=1, out_domain=1; drop_err=0.
- p_bank_domain=1; send src=0 with flag=1 → no out_val; drop_err pulses one cycle; drop_count=1. Then send src=1 with flag=0 → delivered.
- out_rdy=0; send 3 messages A,B,C → A and B accepted, in_rdy=0 while C is held. Raise out_rdy → A, B, C emerge in order, and C is accepted the cycle after A dequeues.
- Continuous streaming with in_val=out_rdy=1 for 10 messages → one accept and one output per cycle after 1-cycle latency; pointers wrap with no loss or duplication.
- p_bank_domain=1; 300 consecutive domain-0 drops → drop_count saturates at 255, drop_err high throughout.
- Assert reset with 2 entries queued mid-stream → out_val=0 and in_rdy=1 immediately; drop_count=0; no stale entry appears after release.
